pmd85_keyboard_matrix: RTL and testbench
========================================

PMD85_KEYBOARD_MATRIX -- requirements
Module: pmd85_keyboard_matrix

Interface
REQ-001 Clocking/reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 clk_sys  input  1  system clock, 18.432 MHz; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 ps2_key  input  11  keyboard event from hps_io: [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode.
REQ-005 col_sel  input  4  column select from the 8255 port A low nibble; values 0..14 select a column, 15 selects none.
REQ-006 row_n  output  5  active-low row sense for the selected column, read by the 8255 port B.
REQ-007 shift_n  output  1  active-low SHIFT key state, independent of column.
REQ-008 stop_n  output  1  active-low STOP key state, independent of column.
REQ-009 reset_req  output  1  active-high request to the top-level reset OR.

Function
REQ-010 Event detection: new event SHALL be ps2_key[10] differing from its value registered on the previous clk_sys cycle.
REQ-011 Each event SHALL be decoded by the keymap into {valid, col[3:0], row[2:0], is_shift, is_stop}; invalid codes SHALL be ignored with no state change.
REQ-012 Key matrix SHALL be 15x5 bits, 1 = pressed: bit set on press event, cleared on release event, one cycle after detection.
REQ-013 Both PC shift keys (0x12, 0x59) SHALL map to SHIFT; shift_n SHALL be low while either is held; release of one SHALL NOT release the other.
REQ-014 STOP SHALL map to Esc (0x76); stop_n low while held.
REQ-015 row_n SHALL be registered: row_n = ~matrix[col_sel] sampled one cycle after col_sel; col_sel 15 SHALL give row_n = 5'b11111.
REQ-016 Latency: ps2_key[10] toggle at edge N SHALL be visible on row_n/shift_n/stop_n at edge N+2 (detect, update) plus 1 for row_n (N+3).
REQ-017 Repeated press events of a held key (typematic) SHALL leave state unchanged; a release of an unpressed key SHALL leave state unchanged.
REQ-018 Multiple keys SHALL be held simultaneously without limit; no ghosting logic.
REQ-019 Extended flag SHALL participate in decode: E0-prefixed arrows map to cursor keys; un-prefixed codes with the same value map per the non-extended table.

Reset
REQ-020 On reset: matrix all 0, shift/stop state 0, toggle register loaded from ps2_key[10] (no spurious event), row_n = 5'b11111, shift_n = 1, stop_n = 1, reset_req = 0.
REQ-021 Reset asserted mid-key-hold SHALL clear the key; the subsequent release event SHALL be a no-op.

Configuration
REQ-022 Macro PMD85_KBD_RESETKEY_EN SHALL gate the reset-key generator.
REQ-023 With it defined: FSM IDLE -> ARMED when LCtrl (0x14) and LAlt (0x11) both held and Delete (E0 0x71) pressed; ARMED -> PULSE next cycle; PULSE drives reset_req = 1 for exactly 16 clk_sys cycles (4-bit counter), then -> WAIT; WAIT -> IDLE when Delete released.
REQ-024 In WAIT, further Delete presses SHALL NOT retrigger; reset input SHALL force IDLE with reset_req = 0 immediately.
REQ-025 Without it: reset_req tied to 0, no FSM or counter synthesised; Ctrl/Alt/Delete behave as plain matrix keys if mapped.

Structure
REQ-026 Package pmd85_kbd_pkg SHALL hold NUM_COLS = 15, NUM_ROWS = 5, COL_NONE = 4'd15, the keymap result struct, and the reset-FSM state enum.
REQ-027 Sub-module pmd85_kbd_keymap SHALL be the combinational scancode-plus-extended to keymap-result decoder; all other logic stays in pmd85_keyboard_matrix.

Verification
REQ-028 Reset, col_sel = 0, no events -> row_n = 5'b11111, shift_n = 1, stop_n = 1, reset_req = 0.
REQ-029 Press key mapped to col 3 row 2, col_sel = 3 -> row_n = 5'b11011 at N+3; col_sel = 4 -> 5'b11111; release -> col 3 returns 5'b11111.
REQ-030 Press LShift, press RShift, release LShift -> shift_n stays 0; release RShift -> shift_n = 1.
REQ-031 Same press event toggled twice, then single release -> key cleared; release of never-pressed key -> no change.
REQ-032 With PMD85_KBD_RESETKEY_EN: LCtrl+LAlt held, press E0 71 -> reset_req high exactly 16 cycles; second Delete press before release -> no pulse; reset during PULSE -> reset_req low next edge.
REQ-033 col_sel = 15 with keys held in all columns -> row_n = 5'b11111.

Source files
------------

// File: rtl/pmd85_kbd_pkg.sv
// rtl/pmd85_kbd_pkg.sv - shared types and constants for the PMD85 keyboard matrix
package pmd85_kbd_pkg;

    localparam int NUM_COLS = 15;
    localparam int NUM_ROWS = 5;
    localparam logic [3:0] COL_NONE = 4'd15;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_LCTRL  = 8'h14;
    localparam logic [7:0] SC_LALT   = 8'h11;
    localparam logic [7:0] SC_DEL    = 8'h71;

    typedef struct packed {
        logic       valid;
        logic [3:0] col;
        logic [2:0] row;
        logic       is_shift;
        logic       is_stop;
    } keymap_t;

    typedef enum logic [1:0] {
        RK_IDLE  = 2'd0,
        RK_ARMED = 2'd1,
        RK_PULSE = 2'd2,
        RK_WAIT  = 2'd3
    } rk_state_t;

    function automatic keymap_t key_at(input int c, input int r);
        key_at = '{valid: 1'b1, col: 4'(c), row: 3'(r), is_shift: 1'b0, is_stop: 1'b0};
    endfunction

endpackage

// File: rtl/pmd85_keyboard_matrix_if.sv
// rtl/pmd85_keyboard_matrix_if.sv - keyboard event input and 8255-side matrix outputs
interface pmd85_keyboard_matrix_if;
    logic [10:0] ps2_key;
    logic [3:0]  col_sel;
    logic [4:0]  row_n;
    logic        shift_n;
    logic        stop_n;
    logic        reset_req;

    modport master (output ps2_key, col_sel, input row_n, shift_n, stop_n, reset_req);
    modport slave  (input ps2_key, col_sel, output row_n, shift_n, stop_n, reset_req);
endinterface

// File: rtl/pmd85_kbd_keymap.sv
// rtl/pmd85_kbd_keymap.sv - combinational PS/2 set-2 scancode to PMD85 matrix position decoder
module pmd85_kbd_keymap
    import pmd85_kbd_pkg::*;
(
    input  logic       i_extended,
    input  logic [7:0] i_scancode,
    output keymap_t    o_map
);

    // Un-prefixed keypad codes share values with E0 cursor codes; the extended bit keeps them apart.
    always_comb begin
        o_map = '0;
        case ({i_extended, i_scancode})
            9'h012, 9'h059: o_map = '{valid: 1'b1, col: 4'd0, row: 3'd0, is_shift: 1'b1, is_stop: 1'b0};
            9'h076:         o_map = '{valid: 1'b1, col: 4'd0, row: 3'd0, is_shift: 1'b0, is_stop: 1'b1};
            9'h005: o_map = key_at(0, 0);   9'h006: o_map = key_at(1, 0);
            9'h004: o_map = key_at(2, 0);   9'h00C: o_map = key_at(3, 0);
            9'h003: o_map = key_at(4, 0);   9'h00B: o_map = key_at(5, 0);
            9'h083: o_map = key_at(6, 0);   9'h00A: o_map = key_at(7, 0);
            9'h001: o_map = key_at(8, 0);   9'h009: o_map = key_at(9, 0);
            9'h078: o_map = key_at(10, 0);  9'h007: o_map = key_at(11, 0);
            9'h016: o_map = key_at(0, 1);   9'h01E: o_map = key_at(1, 1);
            9'h026: o_map = key_at(2, 1);   9'h025: o_map = key_at(3, 1);
            9'h02E: o_map = key_at(4, 1);   9'h036: o_map = key_at(5, 1);
            9'h03D: o_map = key_at(6, 1);   9'h03E: o_map = key_at(7, 1);
            9'h046: o_map = key_at(8, 1);   9'h045: o_map = key_at(9, 1);
            9'h04E: o_map = key_at(10, 1);  9'h055: o_map = key_at(11, 1);
            9'h066: o_map = key_at(12, 1);
            9'h072: o_map = key_at(1, 1);   9'h06B: o_map = key_at(3, 1);
            9'h074: o_map = key_at(5, 1);   9'h06C: o_map = key_at(6, 1);
            9'h075: o_map = key_at(7, 1);
            9'h015: o_map = key_at(0, 2);   9'h01D: o_map = key_at(1, 2);
            9'h024: o_map = key_at(2, 2);   9'h02D: o_map = key_at(3, 2);
            9'h02C: o_map = key_at(4, 2);   9'h035: o_map = key_at(5, 2);
            9'h03C: o_map = key_at(6, 2);   9'h043: o_map = key_at(7, 2);
            9'h044: o_map = key_at(8, 2);   9'h04D: o_map = key_at(9, 2);
            9'h054: o_map = key_at(10, 2);  9'h05B: o_map = key_at(11, 2);
            9'h05A, 9'h15A: o_map = key_at(12, 2);
            9'h01C: o_map = key_at(0, 3);   9'h01B: o_map = key_at(1, 3);
            9'h023: o_map = key_at(2, 3);   9'h02B: o_map = key_at(3, 3);
            9'h034: o_map = key_at(4, 3);   9'h033: o_map = key_at(5, 3);
            9'h03B: o_map = key_at(6, 3);   9'h042: o_map = key_at(7, 3);
            9'h04B: o_map = key_at(8, 3);   9'h04C: o_map = key_at(9, 3);
            9'h052: o_map = key_at(10, 3);
            9'h01A: o_map = key_at(0, 4);   9'h022: o_map = key_at(1, 4);
            9'h021: o_map = key_at(2, 4);   9'h02A: o_map = key_at(3, 4);
            9'h032: o_map = key_at(4, 4);   9'h031: o_map = key_at(5, 4);
            9'h03A: o_map = key_at(6, 4);   9'h041: o_map = key_at(7, 4);
            9'h049: o_map = key_at(8, 4);   9'h04A: o_map = key_at(9, 4);
            9'h071: o_map = key_at(8, 4);   9'h029: o_map = key_at(10, 4);
            9'h175: o_map = key_at(12, 3);  9'h172: o_map = key_at(12, 4);
            9'h16B: o_map = key_at(13, 3);  9'h174: o_map = key_at(13, 4);
            9'h16C: o_map = key_at(14, 0);  9'h171: o_map = key_at(14, 1);
            default: o_map = '0;
        endcase
    end

endmodule

// File: rtl/pmd85_keyboard_matrix.sv
// rtl/pmd85_keyboard_matrix.sv - PS/2 event to PMD85 15x5 key matrix; PMD85_KBD_RESETKEY_EN adds Ctrl+Alt+Del reset pulse
module pmd85_keyboard_matrix
    import pmd85_kbd_pkg::*;
(
    input  logic                      clk_sys,
    input  logic                      reset,
    pmd85_keyboard_matrix_if.slave    kbd
);

    logic                               r_toggle;
    logic                               r_evt_vld;
    logic [9:0]                         r_evt_key;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0]  r_matrix;
    logic [1:0]                         r_shift;
    logic                               r_stop;
    logic [NUM_ROWS-1:0]                r_row_n;
    keymap_t                            w_map;
    logic                               w_evt_press;
    logic [15:0][NUM_ROWS-1:0]          w_cols;

    pmd85_kbd_keymap u_keymap (
        .i_extended (r_evt_key[8]),
        .i_scancode (r_evt_key[7:0]),
        .o_map      (w_map)
    );

    assign w_evt_press = r_evt_key[9];
    // Pad to 16 columns so col_sel can index directly; the pad column reads as released.
    assign w_cols      = {{((16 - NUM_COLS) * NUM_ROWS){1'b0}}, r_matrix};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_toggle  <= kbd.ps2_key[10];
            r_evt_vld <= 1'b0;
            r_evt_key <= '0;
            r_matrix  <= '0;
            r_shift   <= '0;
            r_stop    <= 1'b0;
            r_row_n   <= '1;
        end else begin
            r_toggle  <= kbd.ps2_key[10];
            r_evt_vld <= (kbd.ps2_key[10] != r_toggle);
            r_evt_key <= kbd.ps2_key[9:0];
            if (r_evt_vld && w_map.valid) begin
                if (w_map.is_shift) begin
                    r_shift[r_evt_key[7:0] == SC_RSHIFT] <= w_evt_press;
                end else if (w_map.is_stop) begin
                    r_stop <= w_evt_press;
                end else begin
                    for (int c = 0; c < NUM_COLS; c++) begin
                        for (int r = 0; r < NUM_ROWS; r++) begin
                            if (w_map.col == 4'(c) && w_map.row == 3'(r)) begin
                                r_matrix[c][r] <= w_evt_press;
                            end
                        end
                    end
                end
            end
            r_row_n <= (kbd.col_sel == COL_NONE) ? '1 : ~w_cols[kbd.col_sel];
        end
    end

    assign kbd.row_n   = r_row_n;
    assign kbd.shift_n = ~(|r_shift);
    assign kbd.stop_n  = ~r_stop;

`ifdef PMD85_KBD_RESETKEY_EN
    rk_state_t  r_rk_state;
    rk_state_t  w_rk_next;
    logic [3:0] r_rk_cnt;
    logic       r_ctrl;
    logic       r_alt;
    logic       r_del;
    logic       w_del_press;

    assign w_del_press = r_evt_vld && w_evt_press && r_evt_key[8] && (r_evt_key[7:0] == SC_DEL);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_rk_state <= RK_IDLE;
            r_rk_cnt   <= '0;
            r_ctrl     <= 1'b0;
            r_alt      <= 1'b0;
            r_del      <= 1'b0;
        end else begin
            r_rk_state <= w_rk_next;
            r_rk_cnt   <= (r_rk_state == RK_PULSE) ? r_rk_cnt + 4'd1 : 4'd0;
            if (r_evt_vld && !r_evt_key[8] && r_evt_key[7:0] == SC_LCTRL) r_ctrl <= w_evt_press;
            if (r_evt_vld && !r_evt_key[8] && r_evt_key[7:0] == SC_LALT)  r_alt  <= w_evt_press;
            if (r_evt_vld && r_evt_key[8] && r_evt_key[7:0] == SC_DEL)    r_del  <= w_evt_press;
        end
    end

    // WAIT holds until Delete is physically up, so typematic repeats cannot retrigger.
    always_comb begin
        w_rk_next = r_rk_state;
        case (r_rk_state)
            RK_IDLE:  if (w_del_press && r_ctrl && r_alt) w_rk_next = RK_ARMED;
            RK_ARMED: w_rk_next = RK_PULSE;
            RK_PULSE: if (r_rk_cnt == 4'hF) w_rk_next = RK_WAIT;
            RK_WAIT:  if (!r_del) w_rk_next = RK_IDLE;
            default:  w_rk_next = RK_IDLE;
        endcase
    end

    assign kbd.reset_req = (r_rk_state == RK_PULSE);
`else
    assign kbd.reset_req = 1'b0;
`endif

endmodule

// File: tb/tb_pmd85_keyboard_matrix.sv
// tb/tb_pmd85_keyboard_matrix.sv - directed self-checking bench for pmd85_keyboard_matrix
module tb_pmd85_keyboard_matrix;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #27 clk = ~clk;

    pmd85_keyboard_matrix_if kbd ();

    pmd85_keyboard_matrix dut (
        .clk_sys (clk),
        .reset   (rst),
        .kbd     (kbd)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_ev(input logic pressed, input logic ext, input logic [7:0] code);
        kbd.ps2_key = {~kbd.ps2_key[10], pressed, ext, code};
    endtask

    task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
        drive_ev(pressed, ext, code);
        tick(4);
    endtask

    task automatic test_reset;
        kbd.ps2_key = {1'b1, 1'b1, 1'b0, 8'h2D};
        kbd.col_sel = 4'd0;
        rst = 1'b1;
        tick(3);
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL reset_row_n: got %b want %b", kbd.row_n, 5'h1F); end
        n_checks++; if (kbd.shift_n !== 1'b1) begin n_fail++; $display("FAIL reset_shift_n: got %b want 1", kbd.shift_n); end
        n_checks++; if (kbd.stop_n !== 1'b1) begin n_fail++; $display("FAIL reset_stop_n: got %b want 1", kbd.stop_n); end
        n_checks++; if (kbd.reset_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", kbd.reset_req); end
        rst = 1'b0;
        tick(4);
        kbd.col_sel = 4'd3;
        tick(2);
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL reset_no_spurious: got %b want %b", kbd.row_n, 5'h1F); end
    endtask

    task automatic test_press_release;
        kbd.col_sel = 4'd3;
        tick(1);
        drive_ev(1'b1, 1'b0, 8'h2D);
        tick(2);
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL latency_n2: got %b want %b", kbd.row_n, 5'h1F); end
        tick(1);
        n_checks++; if (kbd.row_n !== 5'b11011) begin n_fail++; $display("FAIL latency_n3: got %b want %b", kbd.row_n, 5'b11011); end
        kbd.col_sel = 4'd4;
        tick(2);
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL other_col: got %b want %b", kbd.row_n, 5'h1F); end
        kbd.col_sel = 4'd3;
        tick(2);
        n_checks++; if (kbd.row_n !== 5'b11011) begin n_fail++; $display("FAIL col3_again: got %b want %b", kbd.row_n, 5'b11011); end
        key(1'b0, 1'b0, 8'h2D);
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL release_r: got %b want %b", kbd.row_n, 5'h1F); end
    endtask

    task automatic test_shift;
        drive_ev(1'b1, 1'b0, 8'h12);
        tick(1);
        n_checks++; if (kbd.shift_n !== 1'b1) begin n_fail++; $display("FAIL shift_n1: got %b want 1", kbd.shift_n); end
        tick(1);
        n_checks++; if (kbd.shift_n !== 1'b0) begin n_fail++; $display("FAIL shift_n2: got %b want 0", kbd.shift_n); end
        key(1'b1, 1'b0, 8'h59);
        key(1'b0, 1'b0, 8'h12);
        n_checks++; if (kbd.shift_n !== 1'b0) begin n_fail++; $display("FAIL shift_rshift_held: got %b want 0", kbd.shift_n); end
        key(1'b0, 1'b0, 8'h59);
        n_checks++; if (kbd.shift_n !== 1'b1) begin n_fail++; $display("FAIL shift_all_up: got %b want 1", kbd.shift_n); end
    endtask

    task automatic test_stop;
        kbd.col_sel = 4'd0;
        key(1'b1, 1'b0, 8'h76);
        n_checks++; if (kbd.stop_n !== 1'b0) begin n_fail++; $display("FAIL stop_press: got %b want 0", kbd.stop_n); end
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL stop_row: got %b want %b", kbd.row_n, 5'h1F); end
        n_checks++; if (kbd.shift_n !== 1'b1) begin n_fail++; $display("FAIL stop_shift: got %b want 1", kbd.shift_n); end
        key(1'b0, 1'b0, 8'h76);
        n_checks++; if (kbd.stop_n !== 1'b1) begin n_fail++; $display("FAIL stop_release: got %b want 1", kbd.stop_n); end
    endtask

    task automatic test_typematic;
        kbd.col_sel = 4'd1;
        key(1'b1, 1'b0, 8'h1D);
        key(1'b1, 1'b0, 8'h1D);
        n_checks++; if (kbd.row_n !== 5'b11011) begin n_fail++; $display("FAIL typematic_held: got %b want %b", kbd.row_n, 5'b11011); end
        key(1'b0, 1'b0, 8'h1D);
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL typematic_release: got %b want %b", kbd.row_n, 5'h1F); end
        kbd.col_sel = 4'd0;
        key(1'b0, 1'b0, 8'h15);
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL release_unpressed: got %b want %b", kbd.row_n, 5'h1F); end
    endtask

    task automatic test_extended;
        kbd.col_sel = 4'd12;
        key(1'b1, 1'b1, 8'h75);
        n_checks++; if (kbd.row_n !== 5'b10111) begin n_fail++; $display("FAIL ext_up_col12: got %b want %b", kbd.row_n, 5'b10111); end
        kbd.col_sel = 4'd7;
        tick(2);
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL ext_up_col7: got %b want %b", kbd.row_n, 5'h1F); end
        kbd.col_sel = 4'd12;
        key(1'b0, 1'b1, 8'h75);
        kbd.col_sel = 4'd7;
        key(1'b1, 1'b0, 8'h75);
        n_checks++; if (kbd.row_n !== 5'b11101) begin n_fail++; $display("FAIL kp8_col7: got %b want %b", kbd.row_n, 5'b11101); end
        kbd.col_sel = 4'd12;
        tick(2);
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL kp8_col12: got %b want %b", kbd.row_n, 5'h1F); end
        key(1'b0, 1'b0, 8'h75);
    endtask

    task automatic test_invalid;
        kbd.col_sel = 4'd3;
        key(1'b1, 1'b0, 8'h2D);
        key(1'b1, 1'b0, 8'h00);
        key(1'b0, 1'b1, 8'h2D);
        n_checks++; if (kbd.row_n !== 5'b11011) begin n_fail++; $display("FAIL invalid_code: got %b want %b", kbd.row_n, 5'b11011); end
        key(1'b0, 1'b0, 8'h2D);
    endtask

    task automatic test_col_none;
        logic [7:0] codes [15] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A,
                                   8'h01, 8'h09, 8'h78, 8'h07, 8'h66, 8'h6B, 8'h6C};
        logic       exts  [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        logic [4:0] exps  [15] = '{5'h1E, 5'h1E, 5'h1E, 5'h1E, 5'h1E, 5'h1E, 5'h1E, 5'h1E,
                                   5'h1E, 5'h1E, 5'h1E, 5'h1E, 5'h1D, 5'h17, 5'h1E};
        for (int i = 0; i < 15; i++) key(1'b1, exts[i], codes[i]);
        for (int i = 0; i < 15; i++) begin
            kbd.col_sel = 4'(i);
            tick(2);
            n_checks++; if (kbd.row_n !== exps[i]) begin n_fail++; $display("FAIL all_cols[%0d]: got %b want %b", i, kbd.row_n, exps[i]); end
        end
        kbd.col_sel = 4'd15;
        tick(2);
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL col_none: got %b want %b", kbd.row_n, 5'h1F); end
        for (int i = 0; i < 15; i++) key(1'b0, exts[i], codes[i]);
        kbd.col_sel = 4'd14;
        tick(2);
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL all_released: got %b want %b", kbd.row_n, 5'h1F); end
    endtask

    task automatic test_reset_hold;
        kbd.col_sel = 4'd3;
        key(1'b1, 1'b0, 8'h2D);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL reset_clears_key: got %b want %b", kbd.row_n, 5'h1F); end
        key(1'b0, 1'b0, 8'h2D);
        n_checks++; if (kbd.row_n !== 5'h1F) begin n_fail++; $display("FAIL release_after_reset: got %b want %b", kbd.row_n, 5'h1F); end
    endtask

    task automatic test_resetkey;
        int cnt;
        int w;
        key(1'b1, 1'b0, 8'h14);
        key(1'b1, 1'b0, 8'h11);
`ifdef PMD85_KBD_RESETKEY_EN
        drive_ev(1'b1, 1'b1, 8'h71);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin tick(1); if (kbd.reset_req === 1'b1) cnt++; end
        n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL pulse_len: got %0d want 16", cnt); end
        drive_ev(1'b1, 1'b1, 8'h71);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin tick(1); if (kbd.reset_req === 1'b1) cnt++; end
        n_checks++; if (cnt != 0) begin n_fail++; $display("FAIL no_retrigger: got %0d want 0", cnt); end
        key(1'b0, 1'b1, 8'h71);
        drive_ev(1'b1, 1'b1, 8'h71);
        w = 0;
        while (kbd.reset_req !== 1'b1 && w < 20) begin tick(1); w++; end
        n_checks++; if (kbd.reset_req !== 1'b1) begin n_fail++; $display("FAIL second_pulse: got %b want 1", kbd.reset_req); end
        tick(3);
        rst = 1'b1;
        tick(1);
        n_checks++; if (kbd.reset_req !== 1'b0) begin n_fail++; $display("FAIL reset_kills_pulse: got %b want 0", kbd.reset_req); end
        rst = 1'b0;
        tick(4);
        n_checks++; if (kbd.reset_req !== 1'b0) begin n_fail++; $display("FAIL after_reset_idle: got %b want 0", kbd.reset_req); end
        key(1'b0, 1'b1, 8'h71);
`else
        drive_ev(1'b1, 1'b1, 8'h71);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin tick(1); if (kbd.reset_req === 1'b1) cnt++; end
        n_checks++; if (cnt != 0) begin n_fail++; $display("FAIL reset_req_disabled: got %0d want 0", cnt); end
        kbd.col_sel = 4'd14;
        tick(2);
        n_checks++; if (kbd.row_n !== 5'b11101) begin n_fail++; $display("FAIL del_as_key: got %b want %b", kbd.row_n, 5'b11101); end
        key(1'b0, 1'b1, 8'h71);
`endif
        key(1'b0, 1'b0, 8'h14);
        key(1'b0, 1'b0, 8'h11);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        kbd.ps2_key = '0;
        kbd.col_sel = 4'd0;
        test_reset();
        test_press_release();
        test_shift();
        test_stop();
        test_typematic();
        test_extended();
        test_invalid();
        test_col_none();
        test_reset_hold();
        test_resetkey();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
